seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
Parametrised time-multiplexed driver for N common-anode/common-cathode 7-segment digits with decimal points, replacing the fixed 4-digit scanner. It adds:
- a refresh prescaler
- tear-free frame-synchronous input latching
- leading-zero blanking with a floating minus sign
- 16-level brightness PWM
- explicit anode outputs

It sits between the datapath display registers and the board segment/anode pins.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8).
PRESCALE, 50000, clk cycles per digit slot. Must be ≥16 and a multiple of 16.
SEG_ACTIVE_LOW, 1, 1 = segment lit when its output bit is 0.
AN_ACTIVE_LOW, 1, 1 = digit enabled when its anode bit is 0.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
digits  in  4*N_DIGITS  hex nibbles; nibble i = digit i; digit 0 is least significant/rightmost
dp  in  N_DIGITS  decimal point request per digit
neg  in  1  show minus sign
blank_lz  in  1  enable leading-zero blanking
bright  in  4  brightness, 0 = dark, 15 = 15/16 duty
load  in  1  strobe: capture digits/dp/neg/blank_lz
seg  out  8  {dp, g, f, e, d, c, b, a}
an  out  N_DIGITS  digit enables, one-hot active
frame_done  out  1  1-cycle pulse at end of each full scan

Behaviour:
- Reset (async, immediate, also mid-scan):
  - an and seg all inactive (all 1s with default polarity)
  - prescaler = 0, digit index = 0
  - shadow register and pending register cleared to 0
  - pending flag = 0, frame_done = 0
- Prescaler cnt counts 0..PRESCALE-1.
  - At terminal count: index advances i -> i+1, wrapping N_DIGITS-1 -> 0.
  - frame_done = 1 for exactly the cycle in which index wraps to 0.
- Input capture:
  - load = 1 copies digits/dp/neg/blank_lz into the pending register and sets the pending flag.
  - At the wrap cycle, if pending (or load in that same cycle, which takes priority with its new values), the shadow takes the pending values and the flag clears.
  - Displayed data changes only on frame boundaries, never mid-frame.
- Brightness:
  - phase = cnt / (PRESCALE/16), range 0..15.
  - Anode for the current index is active iff phase < bright; all other anodes are inactive.
  - bright is sampled live (not shadowed).
- Glyph selection for digit i (from shadow), in priority order:
  1. Let msd = index of the highest nonzero nibble; msd = 0 if all nibbles are zero.
  2. blank_lz = 1 and i > msd: glyph BLANK, except the minus rule below.
  3. Minus: neg = 1 and value ≠ 0 places '-' at position msd+1 when blank_lz = 1 and msd+1 < N_DIGITS; otherwise '-' overrides digit N_DIGITS-1.
  4. neg with value 0 shows no sign.
  5. Otherwise: hex glyph of the nibble.
  6. dp bit is ORed in for every digit, including blank digits.
  7. Digit 0 is never blanked.
- Segment patterns (active-low g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - minus=0111111, blank=1111111
  - SEG_ACTIVE_LOW = 0 inverts all 8 bits; AN_ACTIVE_LOW = 0 inverts an.
- seg and an are registered and glitch-free. Output latency is 1 cycle from the cnt/index values that select them.

Decomposition:
- Package seg7_pkg holds:
  - the 16 hex glyph constants plus SEG_MINUS and SEG_BLANK (7-bit, active-low canonical)
  - the PWM_STEPS = 16 constant
  - a function for msd computation
- Sub-module seg7_hex_decode: purely combinational nibble -> 7-bit glyph; one instance, muxed on index.

Test Plan (N_DIGITS = 4, PRESCALE = 16, default polarities):
1. Reset/assert rst mid-slot:
   - an = 4'b1111 and seg = 8'hFF in the same cycle.
   - After release, index = 0 and the first frame_done occurs 64 cycles later.
2. digits = 16'h12AF, dp = 0, bright = 15, blank_lz = 0, load once, wait one frame:
   - Slot 0: an = 4'b1110 with seg = 8'h8E (phases 0..14), an = 4'b1111 at phase 15.
   - Slot 1: seg = 8'h88. Slot 2: seg = 8'hA4. Slot 3: seg = 8'hF9.
3. digits = 16'h0050, neg = 1, blank_lz = 1, load:
   - Digit 3 = 8'hFF, digit 2 = 8'hBF, digit 1 = 8'h92, digit 0 = 8'hC0.
   - Then digits = 16'h0000, neg = 1: only digit 0 shows 8'hC0; others 8'hFF.
4. bright = 4, steady data: active anode low for exactly 4 of 16 cycles per slot. bright = 0: an stays 4'b1111 for a full frame.
5. load new digits at cycle 20 of a frame: seg unchanged until after the next frame_done. load coincident with the wrap cycle: new data is visible in slot 0 of the immediately following frame.
6. dp = 4'b0100, digits = 16'h0000, blank_lz = 1: digit 2 = 8'h7F (blank + dp), digit 0 = 8'hC0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the seg7 scan multiplexer.
// Glyphs are canonical active-low {g,f,e,d,c,b,a}; polarity is applied at the outputs.
package seg7_pkg;

    localparam int unsigned PWM_STEPS = 16;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index of the highest nonzero nibble among the first n_digits; 0 when all are zero.
    function automatic logic [3:0] msd_index(input logic [31:0] nibbles, input int unsigned n_digits);
        logic [3:0] msd;
        msd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n_digits && nibbles[4*i +: 4] != 4'h0) begin
                msd = 4'(i);
            end
        end
        return msd;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to canonical active-low 7-segment glyph.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK;
        case (nib_i)
            4'h0: glyph_o = SEG_HEX_0;
            4'h1: glyph_o = SEG_HEX_1;
            4'h2: glyph_o = SEG_HEX_2;
            4'h3: glyph_o = SEG_HEX_3;
            4'h4: glyph_o = SEG_HEX_4;
            4'h5: glyph_o = SEG_HEX_5;
            4'h6: glyph_o = SEG_HEX_6;
            4'h7: glyph_o = SEG_HEX_7;
            4'h8: glyph_o = SEG_HEX_8;
            4'h9: glyph_o = SEG_HEX_9;
            4'hA: glyph_o = SEG_HEX_A;
            4'hB: glyph_o = SEG_HEX_B;
            4'hC: glyph_o = SEG_HEX_C;
            4'hD: glyph_o = SEG_HEX_D;
            4'hE: glyph_o = SEG_HEX_E;
            4'hF: glyph_o = SEG_HEX_F;
            default: glyph_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous input capture,
// leading-zero blanking, floating minus sign and 16-level PWM brightness.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned PRESCALE       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    neg,
    input  logic                    blank_lz,
    input  logic [3:0]              bright,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int unsigned CW   = $clog2(PRESCALE);
    localparam int unsigned IW   = $clog2(N_DIGITS);
    localparam int unsigned SLOT = PRESCALE / PWM_STEPS;

    localparam logic [7:0]          SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    frame_done_q;

    logic [4*N_DIGITS-1:0]   pend_digits_q, sh_digits_q;
    logic [N_DIGITS-1:0]     pend_dp_q, sh_dp_q;
    logic                    pend_neg_q, sh_neg_q;
    logic                    pend_blz_q, sh_blz_q;
    logic                    pend_vld_q;

    logic                    tc, wrap;
    logic [3:0]              phase;
    logic [3:0]              msd, minus_pos, idx4;
    logic [3:0]              nib;
    logic [6:0]              hex_glyph, glyph;
    logic [N_DIGITS-1:0]     an_onehot;

    assign tc    = (cnt_q == CW'(PRESCALE - 1));
    assign wrap  = tc && (idx_q == IW'(N_DIGITS - 1));
    assign cnt_d = tc ? '0 : cnt_q + 1'b1;
    assign idx_d = tc ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    assign phase = 4'(cnt_q / CW'(SLOT));

    assign idx4 = 4'(idx_q);
    assign nib  = sh_digits_q[{idx_q, 2'b00} +: 4];
    assign msd  = msd_index(32'(sh_digits_q), N_DIGITS);

    seg7_hex_decode u_dec (
        .nib_i   (nib),
        .glyph_o (hex_glyph)
    );

    always_comb begin
        if (sh_blz_q && (int'(msd) + 1 < int'(N_DIGITS))) begin
            minus_pos = msd + 4'd1;
        end else begin
            minus_pos = 4'(N_DIGITS - 1);
        end

        // Minus outranks blanking so it can float into the first blanked position.
        glyph = hex_glyph;
        if (sh_neg_q && (|sh_digits_q) && idx4 == minus_pos) begin
            glyph = SEG_MINUS;
        end else if (sh_blz_q && idx4 > msd) begin
            glyph = SEG_BLANK;
        end

        seg_d = {~sh_dp_q[idx_q], glyph};
        if (!SEG_ACTIVE_LOW) begin
            seg_d = ~seg_d;
        end

        an_onehot = '0;
        if (phase < bright) begin
            an_onehot[idx_q] = 1'b1;
        end
        an_d = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            frame_done_q  <= 1'b0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_neg_q    <= 1'b0;
            pend_blz_q    <= 1'b0;
            pend_vld_q    <= 1'b0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_neg_q      <= 1'b0;
            sh_blz_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= wrap;

            if (load) begin
                pend_digits_q <= digits;
                pend_dp_q     <= dp;
                pend_neg_q    <= neg;
                pend_blz_q    <= blank_lz;
                pend_vld_q    <= 1'b1;
            end

            // A load landing on the wrap cycle bypasses pending and still clears the flag.
            if (wrap) begin
                pend_vld_q <= 1'b0;
                if (load) begin
                    sh_digits_q <= digits;
                    sh_dp_q     <= dp;
                    sh_neg_q    <= neg;
                    sh_blz_q    <= blank_lz;
                end else if (pend_vld_q) begin
                    sh_digits_q <= pend_digits_q;
                    sh_dp_q     <= pend_dp_q;
                    sh_neg_q    <= pend_neg_q;
                    sh_blz_q    <= pend_blz_q;
                end
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (4 digits, 16-cycle slots, active-low outputs).
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        neg;
    logic        blank_lz;
    logic [3:0]  bright;
    logic        load;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_mux #(
        .N_DIGITS       (4),
        .PRESCALE       (16),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp         (dp),
        .neg        (neg),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
        bit         cseg;
        bit         cfd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   c0 = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_one(input string nm, input int at, input logic [3:0] a,
                            input logic [7:0] s, input logic fd);
        exp_t x;
        x.at = at; x.name = nm; x.an = a; x.seg = s; x.fd = fd;
        x.cseg = 1'b1; x.cfd = 1'b1;
        sb.push_back(x);
    endtask

    // Sample at cyc base+k shows scan position k; frame_done rides on the last position of each frame.
    task automatic push_frame(input int f, input logic [31:0] segs, input int b, input string nm);
        exp_t       x;
        logic [3:0] oh;
        for (int s = 0; s < 4; s++) begin
            for (int ph = 0; ph < 16; ph++) begin
                oh     = 4'b0001 << s;
                x.at   = base + 64*f + 16*s + ph;
                x.name = nm;
                x.an   = (ph < b) ? ~oh : 4'b1111;
                x.seg  = segs[8*s +: 8];
                x.cseg = (ph < b);
                x.fd   = (s == 3 && ph == 15);
                x.cfd  = 1'b1;
                sb.push_back(x);
            end
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic release_rst();
        rst  = 1'b0;
        c0   = cyc;
        base = c0 + 1;
    endtask

    task automatic drive_load(input logic [15:0] d, input logic [3:0] dpv,
                              input logic n, input logic blz);
        digits   = d;
        dp       = dpv;
        neg      = n;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; digits = '0; dp = '0; neg = 1'b0; blank_lz = 1'b0;
        bright = 4'd15; load = 1'b0;
        @(negedge clk);
        push_one("rst_hold", cyc + 1, 4'hF, 8'hFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        release_rst();
        push_frame(0, 32'hC0C0C0C0, 15, "first_frame");
        push_one("pre_rst", base + 69, 4'hE, 8'hC0, 1'b0);
        push_one("mid_rst", base + 70, 4'hF, 8'hFF, 1'b0);
        do begin
            @(posedge clk);
            #2;
        end while (cyc != base + 70);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        release_rst();

        push_frame(0, 32'hC0C0C0C0, 15, "post_rst");
        push_frame(1, 32'hF9A4888E, 15, "hex12AF");
        goto(c0 + 5);
        drive_load(16'h12AF, 4'b0000, 1'b0, 1'b0);

        push_frame(2, 32'hFFBF92C0, 15, "neg0050");
        goto(c0 + 64 + 10);
        drive_load(16'h0050, 4'b0000, 1'b1, 1'b1);

        push_frame(3, 32'hFFFFFFC0, 15, "neg_zero");
        goto(c0 + 128 + 10);
        drive_load(16'h0000, 4'b0000, 1'b1, 1'b1);

        push_frame(4, 32'hFFFFFFC0, 4, "bright4");
        push_frame(5, 32'hFFFFFFC0, 0, "bright0");
        goto(c0 + 256);
        bright = 4'd4;
        goto(c0 + 320);
        bright = 4'd0;

        push_frame(6, 32'hFFFFFFC0, 15, "midload_hold");
        push_frame(7, 32'hB0999282, 15, "midload_new");
        goto(c0 + 384);
        bright = 4'd15;
        goto(c0 + 384 + 20);
        drive_load(16'h3456, 4'b0000, 1'b0, 1'b0);

        push_frame(8, 32'hF8809083, 15, "wrap_load");
        goto(c0 + 480);
        drive_load(16'hDEAD, 4'b0000, 1'b0, 1'b0);
        goto(c0 + 511);
        drive_load(16'h789B, 4'b0000, 1'b0, 1'b0);

        push_frame(9, 32'hFF7FFFC0, 15, "dp_blank");
        goto(c0 + 512 + 10);
        drive_load(16'h0000, 4'b0100, 1'b0, 1'b1);

        stim_done = 1'b1;
    end

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed sample: due cyc %0d, now %0d", e.name, e.at, cyc);
            end else begin
                checks++;
                if (an !== e.an) begin
                    errors++;
                    $display("FAIL %s an @%0d: got %b want %b", e.name, cyc, an, e.an);
                end
                if (e.cseg) begin
                    checks++;
                    if (seg !== e.seg) begin
                        errors++;
                        $display("FAIL %s seg @%0d: got %h want %h", e.name, cyc, seg, e.seg);
                    end
                end
                if (e.cfd) begin
                    checks++;
                    if (frame_done !== e.fd) begin
                        errors++;
                        $display("FAIL %s frame_done @%0d: got %b want %b", e.name, cyc, frame_done, e.fd);
                    end
                end
            end
        end
        if ((stim_done && sb.size() == 0) || cyc > 3000) begin
            if (sb.size() != 0 || !stim_done) begin
                checks++;
                errors++;
                $display("FAIL timeout: %0d expectations outstanding at cyc %0d", sb.size(), cyc);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
